// File: rtl/fsm_lat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_lat_pkg
// Brief    : Shared state encoding and width helpers for the latching sequencer.
// Revision : 1.0
// ============================================================================
package fsm_lat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int hold_w(input int hold_cyc);
        return $clog2(hold_cyc) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lat_buf.sv
`default_nettype none
// ============================================================================
// Module   : lat_buf
// Brief    : DEPTH x IN_W register file, one write port, one async read port.
// Revision : 1.0
// ============================================================================
module lat_buf #(
    parameter int DEPTH = 4,
    parameter int IN_W  = 5,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [IN_W-1:0]  i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [IN_W-1:0]  o_rdata
);

    logic [IN_W-1:0] r_mem [DEPTH];

    // Storage is intentionally not reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (i_we && (32'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (32'(i_raddr) < DEPTH) begin
            o_rdata = r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fsm_lat_seq.sv
`default_nettype none
// ============================================================================
// Module   : fsm_lat_seq
// Brief    : Captures up to DEPTH words and replays them, HOLD_CYC cycles each.
// Revision : 1.0
// ============================================================================
module fsm_lat_seq
    import fsm_lat_pkg::*;
#(
    parameter int IN_W     = 5,
    parameter int OUT_W    = 8,
    parameter int DEPTH    = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [IN_W-1:0]  in,
    input  logic             REG_STATE,
    input  logic             run,
    input  logic             loop_en,
    output logic [OUT_W-1:0] out,
    output logic             busy,
    output logic             full,
    output logic             done,
    output logic             err
);

    localparam int c_PTR_W  = ptr_w(DEPTH);
    localparam int c_CNT_W  = cnt_w(DEPTH);
    localparam int c_HOLD_W = hold_w(HOLD_CYC);

    localparam logic [c_HOLD_W-1:0] c_HOLD_RLD  = c_HOLD_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0]  c_LAST_PTR  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    if ((OUT_W < IN_W + 1) || (DEPTH < 2) || (HOLD_CYC < 1)) begin : g_bad_params
        $error("fsm_lat_seq: illegal parameter combination");
    end

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_count, w_count_nxt;
    logic [c_PTR_W-1:0]  r_wr_ptr, w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]  r_rd_ptr, w_rd_ptr_nxt;
    logic [c_HOLD_W-1:0] r_hold, w_hold_nxt;
    logic                r_err, w_err_nxt;
    logic [OUT_W-1:0]    r_out, w_out_nxt;
    logic                r_busy, r_full, r_done;

    logic                w_we;
    logic [c_PTR_W-1:0]  w_waddr;
    logic [IN_W-1:0]     w_rdata;
    logic                w_at_last;

    lat_buf #(
        .DEPTH (DEPTH),
        .IN_W  (IN_W),
        .PTR_W (c_PTR_W)
    ) u_buf (
        .clk     (clk_in),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (in),
        .i_raddr (w_rd_ptr_nxt),
        .o_rdata (w_rdata)
    );

    assign w_at_last = (c_CNT_W'(r_rd_ptr) == (r_count - c_CNT_W'(1)));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_hold   <= '0;
            r_err    <= 1'b0;
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_full   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_hold   <= w_hold_nxt;
            r_err    <= w_err_nxt;
            r_out    <= w_out_nxt;
            r_busy   <= (w_state_nxt == PLAY);
            r_full   <= (w_count_nxt == c_DEPTH_CNT);
            r_done   <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_hold_nxt   = r_hold;
        w_err_nxt    = r_err;
        w_we         = 1'b0;
        w_waddr      = r_wr_ptr;
        case (r_state)
            IDLE: begin
                if (REG_STATE) begin
                    w_we         = 1'b1;
                    w_waddr      = '0;
                    w_count_nxt  = c_CNT_ONE;
                    w_wr_ptr_nxt = c_PTR_ONE;
                    w_state_nxt  = LOAD;
                end
            end
            LOAD: begin
                // A capture strobe always beats run in the same cycle.
                if (REG_STATE) begin
                    if (r_count < c_DEPTH_CNT) begin
                        w_we        = 1'b1;
                        w_count_nxt = r_count + c_CNT_ONE;
                        if (r_wr_ptr != c_LAST_PTR) begin
                            w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (run) begin
                    w_state_nxt  = PLAY;
                    w_rd_ptr_nxt = '0;
                    w_hold_nxt   = c_HOLD_RLD;
                end
            end
            PLAY: begin
                if (REG_STATE) begin
                    w_err_nxt = 1'b1;
                end
                if (run) begin
                    w_rd_ptr_nxt = '0;
                    w_hold_nxt   = c_HOLD_RLD;
                end else if (r_hold != '0) begin
                    w_hold_nxt = r_hold - c_HOLD_ONE;
                end else if (!w_at_last) begin
                    w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
                    w_hold_nxt   = c_HOLD_RLD;
                end else if (loop_en) begin
                    w_rd_ptr_nxt = '0;
                    w_hold_nxt   = c_HOLD_RLD;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (REG_STATE) begin
                    w_we         = 1'b1;
                    w_waddr      = '0;
                    w_count_nxt  = c_CNT_ONE;
                    w_wr_ptr_nxt = c_PTR_ONE;
                    w_rd_ptr_nxt = '0;
                    w_state_nxt  = LOAD;
                end else if (run) begin
                    w_state_nxt  = PLAY;
                    w_rd_ptr_nxt = '0;
                    w_hold_nxt   = c_HOLD_RLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The read port follows the next read pointer so out lines up with the next state.
    always_comb begin
        w_out_nxt = '0;
        if ((w_state_nxt == PLAY) || (w_state_nxt == DONE)) begin
            w_out_nxt[IN_W-1:0] = w_rdata;
        end
        w_out_nxt[OUT_W-1] = (w_state_nxt == PLAY);
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign full = r_full;
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fsm_lat_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_lat_seq
// Brief    : Directed self-checking bench for fsm_lat_seq (DEPTH=4, HOLD_CYC=2).
// Revision : 1.0
// ============================================================================
module tb_fsm_lat_seq;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [4:0] in_w;
    logic       reg_state;
    logic       run;
    logic       loop_en;
    logic [7:0] out;
    logic       busy, full, done, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] seq [9];

    fsm_lat_seq #(
        .IN_W     (5),
        .OUT_W    (8),
        .DEPTH    (4),
        .HOLD_CYC (2)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .in        (in_w),
        .REG_STATE (reg_state),
        .run       (run),
        .loop_en   (loop_en),
        .out       (out),
        .busy      (busy),
        .full      (full),
        .done      (done),
        .err       (err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic cap(input logic [4:0] v);
        reg_state = 1'b1;
        in_w      = v;
        step();
        reg_state = 1'b0;
    endtask

    // Steps n cycles, releasing run after the first, comparing out against seq.
    task automatic play_expect(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            run = 1'b0;
            check(tag, 32'(out), 32'(seq[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; reg_state = 1'b1; in_w = 5'h1F; run = 1'b0; loop_en = 1'b0;
        step();
        step();
        reset = 1'b0; reg_state = 1'b0;
        check("rst_out",   32'(out),  32'h00);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_full",  32'(full), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err),  32'd0);
        check("rst_state", 32'(dut.r_state), 32'd0);

        // One-shot playback of three entries
        cap(5'h01); cap(5'h02); cap(5'h03);
        check("load_out",   32'(out), 32'h00);
        check("load_count", 32'(dut.r_count), 32'd3);
        seq = '{8'h81, 8'h81, 8'h82, 8'h82, 8'h83, 8'h83, 8'h03, 8'h00, 8'h00};
        run = 1'b1;
        play_expect("oneshot", 7);
        check("oneshot_done", 32'(done), 32'd1);
        check("oneshot_busy", 32'(busy), 32'd0);
        step();
        check("done_hold_out",  32'(out),  32'h03);
        check("done_hold_done", 32'(done), 32'd1);

        // Capture from DONE restarts the buffer, then fill and overflow
        cap(5'h0A);
        check("reload_count", 32'(dut.r_count), 32'd1);
        check("reload_done",  32'(done), 32'd0);
        cap(5'h0B); cap(5'h0C);
        check("not_full", 32'(full), 32'd0);
        cap(5'h0D);
        check("full4", 32'(full), 32'd1);
        check("err4",  32'(err),  32'd0);
        cap(5'h0E);
        check("err5",   32'(err),  32'd1);
        check("full5",  32'(full), 32'd1);
        check("count5", 32'(dut.r_count), 32'd4);
        seq = '{8'h8A, 8'h8A, 8'h8B, 8'h8B, 8'h8C, 8'h8C, 8'h8D, 8'h8D, 8'h0D};
        run = 1'b1;
        play_expect("fullplay", 9);
        check("fullplay_done", 32'(done), 32'd1);
        check("fullplay_err",  32'(err),  32'd1);

        // DONE with capture beats nothing else; then run+capture collision in LOAD
        cap(5'h07);
        check("done_cap_count", 32'(dut.r_count), 32'd1);
        check("done_cap_done",  32'(done), 32'd0);
        check("done_cap_state", 32'(dut.r_state), 32'd1);
        check("done_cap_out",   32'(out), 32'h00);
        run = 1'b1;
        cap(5'h08);
        run = 1'b0;
        check("coll_count", 32'(dut.r_count), 32'd2);
        check("coll_busy",  32'(busy), 32'd0);
        check("coll_state", 32'(dut.r_state), 32'd1);
        step();
        check("coll_idle_busy", 32'(busy), 32'd0);
        check("coll_idle_out",  32'(out),  32'h00);

        // Fresh start: loop mode, restart mid-entry, then loop_en drop at wrap
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_err",  32'(err),  32'd0);
        check("rst2_full", 32'(full), 32'd0);
        cap(5'h11); cap(5'h12);
        loop_en = 1'b1;
        seq = '{8'h91, 8'h91, 8'h92, 8'h92, 8'h91, 8'h91, 8'h92, 8'h00, 8'h00};
        run = 1'b1;
        play_expect("loop", 7);
        run = 1'b1;
        step();
        run = 1'b0;
        check("restart", 32'(out), 32'h91);
        step();
        check("restart_h", 32'(out), 32'h91);
        step();
        check("restart_n", 32'(out), 32'h92);
        loop_en = 1'b0;
        step();
        check("wrap_hold", 32'(out), 32'h92);
        step();
        check("wrap_stop_out",  32'(out),  32'h12);
        check("wrap_stop_done", 32'(done), 32'd1);

        // Reset asserted mid-playback
        reset = 1'b1;
        step();
        reset = 1'b0;
        cap(5'h01); cap(5'h02); cap(5'h03);
        seq = '{8'h81, 8'h81, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run = 1'b1;
        play_expect("midplay", 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_out",   32'(out),  32'h00);
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_count", 32'(dut.r_count), 32'd0);
        check("midrst_state", 32'(dut.r_state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
